// File: rtl/prim_diff_ping_sched.sv
// prim_diff_ping_sched
//
// Round-robin ping scheduler for a bank of differential alert channels.
// After an idle wait it requests a ping on one channel and gives that
// channel a bounded window to acknowledge. It then moves on to the next
// channel, whether or not the acknowledge arrived.
//
// Ports
//   clk_i          block clock, rising edge
//   rst_ni         asynchronous active-low reset
//   en_i           scheduler enable (level)
//   wait_cyc_i     idle cycles between pings, sampled on entry to WAIT
//   timeout_cyc_i  response window, sampled on entry to PING
//   ping_ok_i      per-channel ping acknowledge pulses
//   sigint_i       per-channel signal-integrity flags
//   ping_req_o     one-hot ping request, held for the whole PING phase
//   ping_fail_o    one-cycle pulse, the pinged channel timed out
//   spurious_o     one-cycle pulse, an acknowledge arrived unexpectedly
//   integ_fail_o   registered sigint_i, masked by en_i
//   ch_idx_o       channel currently pinged, or the next one to be pinged
//   busy_o         high whenever the scheduler is not idle
module prim_diff_ping_sched #(
  parameter int NumCh    = 4,
  parameter int WaitW    = 16,
  parameter int TimeoutW = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [WaitW-1:0]         wait_cyc_i,
  input  logic [TimeoutW-1:0]      timeout_cyc_i,
  input  logic [NumCh-1:0]         ping_ok_i,
  input  logic [NumCh-1:0]         sigint_i,
  output logic [NumCh-1:0]         ping_req_o,
  output logic [NumCh-1:0]         ping_fail_o,
  output logic [NumCh-1:0]         spurious_o,
  output logic [NumCh-1:0]         integ_fail_o,
  output logic [$clog2(NumCh)-1:0] ch_idx_o,
  output logic                     busy_o
);

  localparam int IdxW = $clog2(NumCh);
  // A single counter serves both phases, so it is sized for the wider one.
  localparam int CntW = (WaitW > TimeoutW) ? WaitW : TimeoutW;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StPing
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NumCh-1:0]  pingFail_q, pingFail_d;
  logic [NumCh-1:0]  spur_q, spur_d;
  logic [NumCh-1:0]  integ_q, integ_d;

  logic [NumCh-1:0]  sel;
  logic [IdxW-1:0]   idxInc;

  // One-hot decode of the current channel and its modulo-NumCh successor.
  // NumCh need not be a power of two, so the wrap is explicit.
  always_comb begin
    sel    = NumCh'(1) << idx_q;
    idxInc = (idx_q == IdxW'(NumCh - 1)) ? '0 : idx_q + IdxW'(1);
  end

  // Next-state logic for the IDLE/WAIT/PING scheduler. Dropping the enable
  // overrides everything else. It parks the FSM in IDLE and leaves the
  // counter and channel index untouched, so the rotation resumes where it
  // stopped. An acknowledge is checked before the timeout, so an ack that
  // lands on the last window cycle still counts as a success.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pingFail_d = '0;

    if (!en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWait;
          cnt_d   = CntW'(wait_cyc_i);
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_d = StPing;
            cnt_d   = CntW'(timeout_cyc_i);
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StPing: begin
          if ((ping_ok_i & sel) != '0) begin
            state_d = StWait;
            cnt_d   = CntW'(wait_cyc_i);
            idx_d   = idxInc;
          end else if (cnt_q == '0) begin
            state_d    = StWait;
            cnt_d      = CntW'(wait_cyc_i);
            idx_d      = idxInc;
            pingFail_d = sel;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Event flags for the next cycle. During PING, only an acknowledge from a
  // channel other than the pinged one is unexpected. In any other state,
  // every acknowledge is unexpected while the scheduler is enabled.
  always_comb begin
    if (state_q == StPing) begin
      spur_d = ping_ok_i & ~sel;
    end else begin
      spur_d = en_i ? ping_ok_i : '0;
    end
    integ_d = sigint_i & {NumCh{en_i}};
  end

  // State, counter and registered output flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      pingFail_q <= '0;
      spur_q     <= '0;
      integ_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pingFail_q <= pingFail_d;
      spur_q     <= spur_d;
      integ_q    <= integ_d;
    end
  end

  // The ping request is decoded from registered state only. It therefore
  // drops as soon as reset asserts or the FSM leaves PING.
  assign ping_req_o   = (state_q == StPing) ? sel : '0;
  assign ping_fail_o  = pingFail_q;
  assign spurious_o   = spur_q;
  assign integ_fail_o = integ_q;
  assign ch_idx_o     = idx_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_prim_diff_ping_sched.sv
// Testbench for prim_diff_ping_sched: a vector table, targeted scheduling
// scenarios and randomized traffic compared against a behavioural model.
module tb_prim_diff_ping_sched;

  localparam int N  = 4;
  localparam int WW = 16;
  localparam int TW = 8;
  localparam int IW = $clog2(N);

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_PING = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [WW-1:0] wc = '0;
  logic [TW-1:0] tc = '0;
  logic [N-1:0]  ok = '0;
  logic [N-1:0]  sig = '0;
  logic [N-1:0]  ping_req, ping_fail, spurious, integ_fail;
  logic [IW-1:0] ch_idx;
  logic          busy;

  prim_diff_ping_sched #(.NumCh(N), .WaitW(WW), .TimeoutW(TW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .wait_cyc_i   (wc),
    .timeout_cyc_i(tc),
    .ping_ok_i    (ok),
    .sigint_i     (sig),
    .ping_req_o   (ping_req),
    .ping_fail_o  (ping_fail),
    .spurious_o   (spurious),
    .integ_fail_o (integ_fail),
    .ch_idx_o     (ch_idx),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;

  // Behavioural model: the current phase plus the number of cycles the phase
  // still has to run, and the channel whose turn it is.
  int           mMode = M_IDLE;
  int           mLeft = 0;
  int           mIdx = 0;
  logic [N-1:0] mFail = '0, mSpur = '0, mInteg = '0;

  // Scenario knobs for the automatic acknowledger.
  int            ackDelay[N];
  logic [WW-1:0] wcfg = '0;
  logic [TW-1:0] tcfg = '0;
  logic [N-1:0]  sigCfg = '0;
  int            curRun = 0;
  logic [N-1:0]  prevReq = '0;
  logic [N-1:0]  failSeen = '0;

  typedef struct {
    logic          en;
    logic [WW-1:0] wc;
    logic [TW-1:0] tc;
    logic [N-1:0]  ok;
    logic [N-1:0]  sig;
    logic [N-1:0]  xReq;
    logic [N-1:0]  xFail;
    logic [N-1:0]  xSpur;
    logic [N-1:0]  xInteg;
    logic [IW-1:0] xIdx;
    logic          xBusy;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [N-1:0] oneHot(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic modelReset();
    mMode  = M_IDLE;
    mLeft  = 0;
    mIdx   = 0;
    mFail  = '0;
    mSpur  = '0;
    mInteg = '0;
  endtask

  task automatic modelEnterWait();
    mMode = M_WAIT;
    mLeft = int'(wc) + 1;
    mIdx  = (mIdx + 1) % N;
  endtask

  // One clock edge of the scheduler rules, applied to the inputs present at
  // that edge.
  task automatic modelStep();
    logic [N-1:0] cur;
    cur    = oneHot(mIdx);
    mFail  = '0;
    mInteg = en ? sig : '0;
    mSpur  = (mMode == M_PING) ? (ok & ~cur) : (en ? ok : '0);
    if (!en) begin
      mMode = M_IDLE;
    end else if (mMode == M_IDLE) begin
      mMode = M_WAIT;
      mLeft = int'(wc) + 1;
    end else if (mMode == M_WAIT) begin
      mLeft = mLeft - 1;
      if (mLeft == 0) begin
        mMode = M_PING;
        mLeft = int'(tc) + 1;
      end
    end else begin
      if (ok[mIdx]) begin
        modelEnterWait();
      end else begin
        mLeft = mLeft - 1;
        if (mLeft == 0) begin
          mFail = cur;
          modelEnterWait();
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] xReq,
                             input logic [N-1:0] xFail, input logic [N-1:0] xSpur,
                             input logic [N-1:0] xInteg, input logic [IW-1:0] xIdx,
                             input logic xBusy);
    checkCount++;
    if (ping_req === xReq && ping_fail === xFail && spurious === xSpur &&
        integ_fail === xInteg && ch_idx === xIdx && busy === xBusy) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got req=%b fail=%b spur=%b integ=%b idx=%0d busy=%b, expected req=%b fail=%b spur=%b integ=%b idx=%0d busy=%b",
               name, ping_req, ping_fail, spurious, integ_fail, ch_idx, busy,
               xReq, xFail, xSpur, xInteg, xIdx, xBusy);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, (mMode == M_PING) ? oneHot(mIdx) : '0, mFail, mSpur, mInteg,
                IW'(mIdx), mMode != M_IDLE);
  endtask

  // Drive one cycle of inputs away from the edge, advance the model on the
  // edge, and sample the outputs 1 time unit later.
  task automatic applyStimulus(input logic e, input logic [WW-1:0] w, input logic [TW-1:0] t,
                               input logic [N-1:0] o, input logic [N-1:0] s);
    en  = e;
    wc  = w;
    tc  = t;
    ok  = o;
    sig = s;
    @(posedge clk);
    modelStep();
    #1;
    if (ping_req != '0) curRun = (ping_req == prevReq) ? curRun + 1 : 1;
    else curRun = 0;
    prevReq  = ping_req;
    failSeen = failSeen | ping_fail;
  endtask

  // Cycle with the automatic acknowledger: the pinged channel answers
  // during cycle ackDelay+1 of its request. A negative delay means it never
  // answers.
  task automatic autoStep(input logic e, input logic [N-1:0] extra);
    logic [N-1:0] o;
    o = extra;
    if (e && mMode == M_PING && ackDelay[mIdx] >= 0 && curRun == ackDelay[mIdx] + 1)
      o = o | oneHot(mIdx);
    applyStimulus(e, wcfg, tcfg, o, sigCfg);
    checkModel("sched_cycle");
  endtask

  task automatic runUntilReq(input string name, input logic [N-1:0] target,
                             input int budget, output int steps);
    steps = 0;
    while (ping_req != target && steps < budget) begin
      autoStep(1'b1, '0);
      steps++;
    end
    checkVal(name, int'(ping_req), int'(target));
  endtask

  task automatic measureHigh(output int len);
    logic [N-1:0] target;
    target = ping_req;
    len = 0;
    while (ping_req == target && len < 40) begin
      autoStep(1'b1, '0);
      len++;
    end
  endtask

  task automatic doReset();
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    ok    = '0;
    #1;
    modelReset();
    checkOutput("reset_async", '0, '0, '0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold", '0, '0, '0, '0, '0, 1'b0);
    rst_n    = 1'b1;
    curRun   = 0;
    prevReq  = '0;
    failSeen = '0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int steps;
    int len;
    logic [N-1:0] order[5];

    // Zero-length wait and timeout windows, acks, spurious acks, enable drop.
    tbl[0]  = '{1'b1, 16'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1};
    tbl[1]  = '{1'b1, 16'd0, 8'd0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 16'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd1, 1'b1};
    tbl[3]  = '{1'b1, 16'd0, 8'd0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1};
    tbl[4]  = '{1'b1, 16'd0, 8'd0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1};
    tbl[5]  = '{1'b1, 16'd0, 8'd0, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 2'd2, 1'b1};
    tbl[6]  = '{1'b1, 16'd0, 8'd0, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1};
    tbl[7]  = '{1'b1, 16'd0, 8'd0, 4'b0000, 4'b0011, 4'b1000, 4'b0000, 4'b0000, 4'b0011, 2'd3, 1'b1};
    tbl[8]  = '{1'b0, 16'd0, 8'd0, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[9]  = '{1'b1, 16'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b1};
    tbl[10] = '{1'b1, 16'd0, 8'd0, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b1};
    tbl[11] = '{1'b1, 16'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b1};
    tbl[12] = '{1'b1, 16'd0, 8'd0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1};

    for (int i = 0; i < N; i++) ackDelay[i] = 2;

    $display("[TB] vector table");
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].en, tbl[i].wc, tbl[i].tc, tbl[i].ok, tbl[i].sig);
      checkOutput($sformatf("tbl_vec%0d", i), tbl[i].xReq, tbl[i].xFail, tbl[i].xSpur,
                  tbl[i].xInteg, tbl[i].xIdx, tbl[i].xBusy);
    end

    $display("[TB] round robin with timely acks");
    wcfg = WW'(3);
    tcfg = TW'(5);
    sigCfg = '0;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    doReset();
    for (int p = 0; p < 5; p++) begin
      runUntilReq($sformatf("rr_order%0d", p), order[p], 20, steps);
      if (p > 0) checkVal($sformatf("rr_wait_gap%0d", p), steps, 4);
      measureHigh(len);
      checkVal($sformatf("rr_req_len%0d", p), len, 3);
    end
    checkVal("rr_no_fail", int'(failSeen), 0);

    $display("[TB] silent channel times out");
    ackDelay[2] = -1;
    doReset();
    runUntilReq("to_reach_ch2", 4'b0100, 60, steps);
    measureHigh(len);
    checkVal("to_req_len", len, 6);
    checkVal("to_fail_pulse", int'(ping_fail), 4);
    autoStep(1'b1, '0);
    checkVal("to_fail_one_cycle", int'(ping_fail), 0);
    runUntilReq("to_next_ch3", 4'b1000, 10, steps);
    ackDelay[2] = 2;

    $display("[TB] ack on the timeout cycle");
    ackDelay[1] = 5;
    doReset();
    runUntilReq("coin_reach_ch1", 4'b0010, 40, steps);
    measureHigh(len);
    checkVal("coin_req_len", len, 6);
    checkVal("coin_no_fail", int'(ping_fail), 0);
    checkVal("coin_idx_adv", int'(ch_idx), 2);
    autoStep(1'b1, '0);
    checkVal("coin_no_fail_late", int'(failSeen), 0);
    ackDelay[1] = 2;

    $display("[TB] spurious acknowledges");
    doReset();
    runUntilReq("spur_reach_ch0", 4'b0001, 20, steps);
    autoStep(1'b1, 4'b1000);
    checkVal("spur_in_ping", int'(spurious), 8);
    checkVal("spur_ping_held", int'(ping_req), 1);
    autoStep(1'b1, '0);
    checkVal("spur_ping_clear", int'(spurious), 0);
    measureHigh(len);
    autoStep(1'b1, 4'b0010);
    checkVal("spur_in_wait", int'(spurious), 2);
    autoStep(1'b1, '0);
    checkVal("spur_wait_clear", int'(spurious), 0);
    runUntilReq("spur_next_ch1", 4'b0010, 20, steps);
    checkVal("spur_wait_timing", steps, 2);

    $display("[TB] enable drop mid ping");
    ackDelay[1] = -1;
    doReset();
    runUntilReq("en_reach_ch1", 4'b0010, 40, steps);
    autoStep(1'b1, '0);
    autoStep(1'b1, '0);
    autoStep(1'b0, '0);
    checkOutput("en_drop", '0, '0, '0, '0, IW'(1), 1'b0);
    autoStep(1'b0, '0);
    checkVal("en_drop_no_fail", int'(failSeen), 0);
    runUntilReq("en_resume_ch1", 4'b0010, 20, steps);
    checkVal("en_resume_delay", steps, 5);
    ackDelay[1] = 2;

    $display("[TB] reset mid ping");
    doReset();
    runUntilReq("rst_reach_ch3", 4'b1000, 60, steps);
    sigCfg = 4'b0100;
    sig    = 4'b0100;
    doReset();
    autoStep(1'b1, '0);
    checkVal("rst_integ", int'(integ_fail), 4);
    runUntilReq("rst_first_ch0", 4'b0001, 20, steps);
    checkVal("rst_no_fail", int'(failSeen), 0);
    sigCfg = '0;

    $display("[TB] randomized traffic");
    doReset();
    for (int i = 0; i < 1500; i++) begin
      logic          e;
      logic [N-1:0]  o;
      e = ($urandom_range(0, 24) != 0);
      o = '0;
      if (e) begin
        o = N'($urandom) & N'($urandom) & N'($urandom);
        if (mMode == M_PING && $urandom_range(0, 3) == 0) o = o | oneHot(mIdx);
      end
      applyStimulus(e, WW'($urandom_range(0, 3)), TW'($urandom_range(0, 4)), o, N'($urandom));
      checkModel("random_cycle");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/prim_diff_ping_sched.md
PRIM_DIFF_PING_SCHED -- requirements
Module: prim_diff_ping_sched

Interface
REQ-001 Parameter NumCh, default 4, number of differential alert channels served (2..16).
REQ-002 Parameter WaitW, default 16, width of the inter-ping wait counter.
REQ-003 Parameter TimeoutW, default 8, width of the ping response timeout counter.
REQ-004 The block SHALL have exactly one clock and an asynchronous, active-low reset, named as the codebase does:
REQ-005 clk_i  input  1  block clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 en_i  input  1  scheduler enable; level.
REQ-008 wait_cyc_i  input  WaitW  idle cycles between pings; sampled on entry to WAIT.
REQ-009 timeout_cyc_i  input  TimeoutW  response window; sampled on entry to PING.
REQ-010 ping_ok_i  input  NumCh  per-channel ping-acknowledge pulse from the channel's differential decoder event.
REQ-011 sigint_i  input  NumCh  per-channel signal-integrity flag from the channel's differential decoder.
REQ-012 ping_req_o  output  NumCh  one-hot ping request to the selected channel, level-held.
REQ-013 ping_fail_o  output  NumCh  one-cycle pulse: selected channel did not answer in time.
REQ-014 spurious_o  output  NumCh  one-cycle pulse: ping_ok_i seen on a non-pinged channel.
REQ-015 integ_fail_o  output  NumCh  registered copy of sigint_i, masked by en_i.
REQ-016 ch_idx_o  output  $clog2(NumCh)  index of the channel currently or next to be pinged.
REQ-017 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT and PING; all outputs are registered or decoded from registered state only.
REQ-019 IDLE: if en_i=1, go to WAIT and load cnt <= wait_cyc_i; else stay.
REQ-020 WAIT: if cnt==0, go to PING and load cnt <= timeout_cyc_i; else cnt decrements by 1; WAIT thus lasts wait_cyc_i+1 cycles.
REQ-021 PING: ping_req_o = one-hot(ch_idx_o) for every cycle in PING; zero in all other states.
REQ-022 PING: if ping_ok_i[ch_idx] = 1, go to WAIT (cnt <= wait_cyc_i), advance ch_idx; no fail pulse.
REQ-023 PING: else if cnt==0, pulse ping_fail_o[ch_idx] in the following cycle, go to WAIT, advance ch_idx.
REQ-024 PING: else cnt decrements; ping_req_o is therefore high for at most timeout_cyc_i+1 cycles.
REQ-025 ping_ok_i and timeout in the same cycle: acknowledge wins, no ping_fail_o.
REQ-026 ch_idx advances by 1 modulo NumCh (NumCh-1 wraps to 0); it never advances in IDLE or WAIT.
REQ-027 ping_ok_i[j] with j != ch_idx, or any ping_ok_i outside PING while en_i=1, SHALL pulse spurious_o[j] one cycle later; multiple bits may pulse together.
REQ-028 en_i=0 in any state: next state IDLE, ping_req_o drops next cycle, no fail pulse, ch_idx retained, cnt unchanged.
REQ-029 integ_fail_o[j] <= sigint_i[j] & en_i each cycle; sigint_i does not alter FSM state or ch_idx.
REQ-030 wait_cyc_i=0 and timeout_cyc_i=0 SHALL be legal: WAIT 1 cycle, PING 1 cycle.
REQ-031 Counter arithmetic SHALL be unsigned and never underflow: decrement only when cnt != 0.

Reset
REQ-032 On rst_ni=0, asynchronously: state=IDLE, cnt=0, ch_idx=0, ping_req_o=0, ping_fail_o=0, spurious_o=0, integ_fail_o=0, busy_o=0.
REQ-033 Reset asserted mid-PING SHALL drop ping_req_o immediately without a fail pulse; after release ping order restarts at channel 0.

Verification
REQ-034 NumCh=4, wait=3, timeout=5, en_i=1, channel acks 2 cycles into each ping -> ping_req_o 0001,0010,0100,1000,0001 in order, each high 3 cycles, 4 cycles of WAIT between, no ping_fail_o.
REQ-035 Same config, channel 2 never acks -> ping_req_o=0100 held 6 cycles, then ping_fail_o=0100 for 1 cycle, next ping targets channel 3.
REQ-036 Ack and timeout coincide on channel 1 (ack in 6th PING cycle, timeout=5) -> no fail pulse, ch_idx advances to 2.
REQ-037 ping_ok_i=1000 while pinging channel 0, and ping_ok_i=0010 during WAIT -> spurious_o=1000 then 0010, each one cycle, FSM unaffected.
REQ-038 en_i dropped in 3rd PING cycle on channel 1 -> ping_req_o=0 next cycle, busy_o=0, no fail; en_i re-raised -> next ping goes to channel 1 after wait.
REQ-039 rst_ni pulsed low mid-PING on channel 3, sigint_i=0100 held -> all outputs 0 during reset; after release with en_i=1, integ_fail_o=0100 one cycle later, first ping to channel 0.
